// File: rtl/btn_debounce_array_if.sv
// Port bundle for btn_debounce_array: raw buttons in, conditioned levels/strobes out.
// No handshake: every output is a registered level or a single-cycle strobe qualified only by clk.
interface btn_debounce_array_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]   btn_in;
  logic [CHANNELS-1:0]   btn_level;
  logic [CHANNELS-1:0]   press_pulse;
  logic [CHANNELS-1:0]   release_pulse;
  logic [CHANNELS-1:0]   long_pulse;
  logic [CHANNELS-1:0]   repeat_pulse;
  logic                  any_pressed;
  // Debug view of each channel's state, 2 bits per channel (0 idle, 1 pressed, 2 long)
  logic [2*CHANNELS-1:0] state;

  modport master (
    input  btn_in,
    output btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse,
    output any_pressed, state
  );

  modport slave (
    output btn_in,
    input  btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse,
    input  any_pressed, state
  );
endinterface

// File: rtl/btn_debounce_array.sv
// Multi-channel button conditioner: 2-flop sync, stable-time debounce, press/release/long strobes.
// Define BTN_DEBOUNCE_ARRAY_REPEAT_EN to add auto-repeat pulses while a button is held past long-press.
module btn_debounce_array #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  btn_debounce_array_if.master bus
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  state_t              state_q [CHANNELS];
  logic [CW-1:0]       cnt_q   [CHANNELS];
  logic [HW-1:0]       hold_q  [CHANNELS];

  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;
  logic [CHANNELS-1:0] level_q;
  logic [CHANNELS-1:0] press_q;
  logic [CHANNELS-1:0] release_q;
  logic [CHANNELS-1:0] long_q;
  logic [CHANNELS-1:0] repeat_q;
  logic                any_q;
  logic [CHANNELS-1:0] mismatch;
  logic [CHANNELS-1:0] toggle;

`ifdef BTN_DEBOUNCE_ARRAY_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0]       rep_q [CHANNELS];
`endif

  assign raw = ACTIVE_LOW ? ~bus.btn_in : bus.btn_in;

  // The level flips on the edge where the STABLE_CYCLES-th consecutive disagreeing sample arrives.
  always_comb begin
    mismatch = '0;
    toggle   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      mismatch[i] = sync2_q[i] != level_q[i];
      toggle[i]   = mismatch[i] && (cnt_q[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        hold_q[i]  <= '0;
`ifdef BTN_DEBOUNCE_ARRAY_REPEAT_EN
        rep_q[i]   <= '0;
`endif
      end
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      level_q   <= level_q ^ toggle;
      press_q   <= toggle & ~level_q;
      release_q <= toggle & level_q;
      any_q     <= |(level_q ^ toggle);
      long_q    <= '0;
      repeat_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (!mismatch[i] || toggle[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end

        // In PRESSED/LONG a toggle is always a release, and it beats the long threshold.
        case (state_q[i])
          IDLE: begin
            hold_q[i] <= '0;
            if (toggle[i]) state_q[i] <= PRESSED;
          end
          PRESSED: begin
            if (toggle[i]) begin
              state_q[i] <= IDLE;
              hold_q[i]  <= '0;
            end else begin
              hold_q[i] <= hold_q[i] + HW'(1);
              if ((hold_q[i] + HW'(1)) == HOLD_MAX) begin
                long_q[i]  <= 1'b1;
                state_q[i] <= LONG;
`ifdef BTN_DEBOUNCE_ARRAY_REPEAT_EN
                rep_q[i]   <= '0;
`endif
              end
            end
          end
          LONG: begin
            if (toggle[i]) begin
              state_q[i] <= IDLE;
              hold_q[i]  <= '0;
`ifdef BTN_DEBOUNCE_ARRAY_REPEAT_EN
              rep_q[i]   <= '0;
`endif
            end else begin
`ifdef BTN_DEBOUNCE_ARRAY_REPEAT_EN
              if (rep_q[i] == REP_MAX) begin
                rep_q[i]    <= '0;
                repeat_q[i] <= 1'b1;
              end else begin
                rep_q[i] <= rep_q[i] + RW'(1);
              end
`endif
            end
          end
          default: begin
            state_q[i] <= IDLE;
            hold_q[i]  <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    bus.state = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.state[2*i +: 2] = state_q[i];
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.any_pressed   = any_q;

endmodule

// File: doc/btn_debounce_array.md
# btn_debounce_array

Multi-channel, counter-based button conditioner for the front-panel inputs: per channel it synchronizes a raw asynchronous button, debounces it with a programmable stable-time counter, and emits clean level, press, release and long-press outputs. It sits between the board pins and the game FSM, replacing per-button debounce instances. Compile-time auto-repeat turns a held button into periodic repeat pulses.

## Interface
- CHANNELS, 4: number of independent button channels (≥1)
- STABLE_CYCLES, 16: consecutive agreeing samples required to change debounced level (≥2)
- LONG_CYCLES, 1000: held cycles after press before long-press event (≥1)
- REPEAT_CYCLES, 200: repeat period after long press (≥1; used only with auto-repeat)
- ACTIVE_LOW, 0: 1 = raw inputs are active-low and are inverted before synchronization
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- btn_in  in  CHANNELS  raw asynchronous button inputs
- btn_level  out  CHANNELS  debounced level, 1 = pressed
- press_pulse  out  CHANNELS  one-cycle pulse on debounced 0→1
- release_pulse  out  CHANNELS  one-cycle pulse on debounced 1→0
- long_pulse  out  CHANNELS  one-cycle pulse when held LONG_CYCLES
- repeat_pulse  out  CHANNELS  one-cycle auto-repeat pulse (0 when feature out)
- any_pressed  out  1  OR of btn_level

## Operation
- Per channel, fully independent; no cross-channel interaction except any_pressed.
- Input polarity: if ACTIVE_LOW, channel input inverted first; all internal logic is active-high.
- Synchronizer: two flops, reset to 0 (released).
- Debounce counter, width $clog2(STABLE_CYCLES): if sync output ≠ btn_level, increment; if equal, clear to 0. When counter = STABLE_CYCLES−1 and mismatch persists, btn_level toggles and counter clears the same edge.
- Any single sample agreeing with current level restarts the count (glitch rejection).
- press_pulse/release_pulse register the toggle; high exactly in the cycle btn_level first shows the new value.
- Hold counter, width $clog2(LONG_CYCLES+1): cleared while btn_level=0 and on the press edge; increments while btn_level=1; saturates at LONG_CYCLES. long_pulse high in the cycle it reaches LONG_CYCLES; at most once per press.
- Release before LONG_CYCLES: no long_pulse; hold counter clears.
- Per-channel states: IDLE (level 0), PRESSED (level 1, hold < LONG_CYCLES), LONG (hold saturated). IDLE→PRESSED on press; PRESSED→LONG on long_pulse; PRESSED/LONG→IDLE on release.
- All outputs registered.

## Timing
- Reset: all synchronizer, counters and outputs 0; no pulses in the reset cycle or in the first cycle after.
- Latency: input change stable before edge E0 → btn_level and press/release pulse visible after edge E(STABLE_CYCLES+1), i.e. STABLE_CYCLES+2 cycles.
- long_pulse: LONG_CYCLES cycles after press_pulse.
- Reset mid-operation: immediate return to IDLE; a button still held reappears with press_pulse STABLE_CYCLES+2 cycles after rst deasserts.
- Release and long threshold on the same edge: release wins; no long_pulse.
- Multiple channels may pulse in the same cycle.

## Configuration
- BTN_DEBOUNCE_ARRAY_REPEAT_EN defined: in LONG state a per-channel repeat counter (width $clog2(REPEAT_CYCLES)) runs; repeat_pulse fires REPEAT_CYCLES cycles after long_pulse and every REPEAT_CYCLES thereafter while held; release or reset clears it, with no repeat_pulse in the release cycle.
- Not defined: repeat counter absent, repeat_pulse tied to 0; all other behavior identical.

## Test plan
- Reset with btn_in=4'b0001 held, STABLE_CYCLES=16 → all outputs 0 during reset; press_pulse[0] exactly 18 cycles after rst falls; btn_level=4'b0001.
- Channel 1 bounce: toggle every 3 cycles for 40 cycles, then stable 1 → no pulses during bounce; single press_pulse[1] 18 cycles after last edge.
- Hold channel 2 for 1100 cycles with LONG_CYCLES=1000 → one long_pulse[2] 1000 cycles after press_pulse[2]; one release_pulse[2] 18 cycles after release.
- Release channel 3 at hold count 999 → release_pulse[3], no long_pulse[3].
- REPEAT_EN defined, REPEAT_CYCLES=200, hold 1650 cycles → repeat_pulse at +200, +400, +600 after long_pulse; none after release; REPEAT_EN undefined → repeat_pulse stays 0.
- ACTIVE_LOW=1, all inputs driven 1 → no activity; drive ch0 low → press_pulse[0] after 18 cycles; rst asserted mid-hold → outputs 0 next cycle.
